// File: rtl/ps2_pkg.sv
// Shared PS/2 decoder types and scan-code constants (set 2), also used by the movement stage.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] PS2_ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] PS2_ARROW_RIGHT = 8'h74;
    localparam logic [7:0] PS2_ARROW_UP    = 8'h75;
    localparam logic [7:0] PS2_ARROW_DOWN  = 8'h72;

    // Odd parity bit for a data byte: makes the 9-bit total odd.
    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the PS/2 lines, glitch-filters ps2_clk and emits a one-cycle strobe on its filtered falling edge.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic strobe
);

    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       filt;
    logic       filt_prev;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            dat_sync  <= 2'b11;
            filt      <= 1'b1;
            filt_prev <= 1'b1;
            cnt       <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            dat_sync  <= {dat_sync[0], ps2_data};
            filt_prev <= filt;
            // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
            if (clk_sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == 8'(FILTER_LEN - 1)) begin
                filt <= clk_sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign data_sync = dat_sync[1];
    assign strobe    = filt_prev & ~filt;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 frame receiver and scan-code set 2 make/break decoder holding the currently pressed key.
// Build option: PS2_PARITY_CHECK_EN enables odd-parity checking of received bytes.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       extended,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT_CYCLES);

    logic          data_sync;
    logic          strobe;
    ps2_state_e    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [TW-1:0] idle_cnt;
    logic          ext_pend;
    logic          brk_pend;
    logic          parity_ok;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_sync(data_sync),
        .strobe   (strobe)
    );

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit;
    assign parity_ok = ^{shift, parity_bit};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            idle_cnt  <= '0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            key_code  <= '0;
            extended  <= 1'b0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            if (state != ST_IDLE && !strobe && idle_cnt == TIMEOUT_T) begin
                // Stalled partial frame: drop it so the next start bit resynchronises.
                state     <= ST_IDLE;
                idle_cnt  <= '0;
                frame_err <= 1'b1;
            end else if (strobe) begin
                idle_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (!data_sync) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift   <= {data_sync, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_bit <= data_sync;
`endif
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (data_sync && parity_ok) begin
                            if (shift == PS2_EXT) begin
                                ext_pend <= 1'b1;
                            end else if (shift == PS2_BRK) begin
                                brk_pend <= 1'b1;
                            end else if (brk_pend) begin
                                // Releasing some other key leaves the held key untouched.
                                if (shift == key_code && ext_pend == extended) begin
                                    key_code <= '0;
                                    extended <= 1'b0;
                                end
                                ext_pend <= 1'b0;
                                brk_pend <= 1'b0;
                            end else begin
                                key_code  <= shift;
                                extended  <= ext_pend;
                                key_valid <= 1'b1;
                                ext_pend  <= 1'b0;
                                brk_pend  <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: drives PS/2 frames and scoreboards every key_valid pulse.
module tb_ps2_key_decoder;
    import ps2_pkg::*;

    localparam int FILT = 8;
    localparam int TMO  = 400;
    localparam int HP   = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_code;
    logic       extended;
    logic       key_valid;
    logic       frame_err;

    logic [8:0] exp_q[$];
    logic [8:0] exp_w;
    int n_cmp     = 0;
    int n_err     = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;

    ps2_key_decoder #(
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_code (key_code),
        .extended (extended),
        .key_valid(key_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every key_valid pulse must match the oldest expected {extended, key_code}.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (key_valid && frame_err) begin
                n_cmp++;
                n_err++;
                $display("FAIL pulse_overlap: key_valid=%b frame_err=%b, required not both", key_valid, frame_err);
            end
            if (key_valid) begin
                valid_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_key: got %h ext=%b, none expected", key_code, extended);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({extended, key_code} !== exp_w) begin
                        n_err++;
                        $display("FAIL key_event: got ext=%b code=%h, required ext=%b code=%h",
                                 extended, key_code, exp_w[8], exp_w[7:0]);
                    end
                end
            end
            if (frame_err) err_cnt++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_clks(HP);
        ps2_clk = 1'b0;
        wait_clks(HP);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(bad_par ? ~ps2_odd_parity(b) : ps2_odd_parity(b));
        send_bit(stop);
        ps2_data = 1'b1;
        wait_clks(HP);
    endtask

    task automatic send_make(input logic [7:0] code, input logic ext);
        if (ext) send_frame(PS2_EXT, 1'b0, 1'b1);
        exp_q.push_back({ext, code});
        send_frame(code, 1'b0, 1'b1);
    endtask

    task automatic send_break(input logic [7:0] code, input logic ext);
        if (ext) send_frame(PS2_EXT, 1'b0, 1'b1);
        send_frame(PS2_BRK, 1'b0, 1'b1);
        send_frame(code, 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_clks(5);
        reset = 1'b1;
        wait_clks(20);
        @(negedge clk);
        n_cmp++; if (key_code !== 8'h00) begin n_err++; $display("FAIL reset_key_code: got %h, required 00", key_code); end
        n_cmp++; if (extended !== 1'b0) begin n_err++; $display("FAIL reset_extended: got %b, required 0", extended); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_key_valid: got %b, required 0", key_valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    endtask

    task automatic test_make;
        int v0;
        v0 = valid_cnt;
        send_make(8'h1C, 1'b0);
        @(negedge clk);
        n_cmp++; if (key_code !== 8'h1C) begin n_err++; $display("FAIL make_code: got %h, required 1c", key_code); end
        n_cmp++; if (extended !== 1'b0) begin n_err++; $display("FAIL make_ext: got %b, required 0", extended); end
        n_cmp++; if (valid_cnt - v0 !== 1) begin n_err++; $display("FAIL make_pulses: got %0d, required 1", valid_cnt - v0); end
        send_break(8'h1C, 1'b0);
        @(negedge clk);
        n_cmp++; if (key_code !== 8'h00) begin n_err++; $display("FAIL make_release: got %h, required 00", key_code); end
    endtask

    task automatic test_extended;
        send_make(PS2_ARROW_LEFT, 1'b1);
        @(negedge clk);
        n_cmp++; if ({extended, key_code} !== 9'h16B) begin n_err++; $display("FAIL ext_make: got %b/%h, required 1/6b", extended, key_code); end
        // A non-extended break of the same code must not release the extended key.
        send_break(PS2_ARROW_LEFT, 1'b0);
        @(negedge clk);
        n_cmp++; if ({extended, key_code} !== 9'h16B) begin n_err++; $display("FAIL ext_plain_break: got %b/%h, required 1/6b", extended, key_code); end
        send_break(PS2_ARROW_LEFT, 1'b1);
        @(negedge clk);
        n_cmp++; if ({extended, key_code} !== 9'h000) begin n_err++; $display("FAIL ext_break: got %b/%h, required 0/00", extended, key_code); end
    endtask

    task automatic test_last_wins;
        send_make(PS2_ARROW_UP, 1'b0);
        send_make(PS2_ARROW_DOWN, 1'b0);
        send_break(PS2_ARROW_UP, 1'b0);
        @(negedge clk);
        n_cmp++; if (key_code !== 8'h72) begin n_err++; $display("FAIL last_wins: got %h, required 72", key_code); end
        send_break(PS2_ARROW_DOWN, 1'b0);
        @(negedge clk);
        n_cmp++; if (key_code !== 8'h00) begin n_err++; $display("FAIL last_release: got %h, required 00", key_code); end
    endtask

    task automatic test_parity;
        int e0;
        e0 = err_cnt;
`ifdef PS2_PARITY_CHECK_EN
        send_frame(8'h1C, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL parity_err: got %0d pulses, required 1", err_cnt - e0); end
        n_cmp++; if (key_code !== 8'h00) begin n_err++; $display("FAIL parity_code: got %h, required 00", key_code); end
`else
        exp_q.push_back({1'b0, 8'h1C});
        send_frame(8'h1C, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL parity_err: got %0d pulses, required 0", err_cnt - e0); end
        n_cmp++; if (key_code !== 8'h1C) begin n_err++; $display("FAIL parity_code: got %h, required 1c", key_code); end
        send_break(8'h1C, 1'b0);
`endif
    endtask

    task automatic test_bad_stop;
        int e0;
        int v0;
        e0 = err_cnt;
        v0 = valid_cnt;
        send_frame(8'h1D, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL stop_err: got %0d pulses, required 1", err_cnt - e0); end
        n_cmp++; if (valid_cnt - v0 !== 0) begin n_err++; $display("FAIL stop_valid: got %0d pulses, required 0", valid_cnt - v0); end
        n_cmp++; if (key_code !== 8'h00) begin n_err++; $display("FAIL stop_code: got %h, required 00", key_code); end
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        wait_clks(TMO / 2);
        n_cmp++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL timeout_early: got %0d pulses, required 0", err_cnt - e0); end
        wait_clks(TMO);
        @(negedge clk);
        n_cmp++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL timeout_err: got %0d pulses, required 1", err_cnt - e0); end
        send_make(PS2_ARROW_RIGHT, 1'b0);
        @(negedge clk);
        n_cmp++; if (key_code !== 8'h74) begin n_err++; $display("FAIL timeout_recover: got %h, required 74", key_code); end
        send_break(PS2_ARROW_RIGHT, 1'b0);
    endtask

    task automatic test_glitch;
        int e0;
        int v0;
        e0 = err_cnt;
        v0 = valid_cnt;
        // Data low during the glitch: a strobe here would be taken as a start bit.
        ps2_data = 1'b0;
        wait_clks(5);
        ps2_clk = 1'b0;
        wait_clks(3);
        ps2_clk = 1'b1;
        wait_clks(20);
        ps2_data = 1'b1;
        wait_clks(5);
        send_make(8'h29, 1'b0);
        @(negedge clk);
        n_cmp++; if (key_code !== 8'h29) begin n_err++; $display("FAIL glitch_code: got %h, required 29", key_code); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL glitch_err: got %0d pulses, required 0", err_cnt - e0); end
        n_cmp++; if (valid_cnt - v0 !== 1) begin n_err++; $display("FAIL glitch_valid: got %0d pulses, required 1", valid_cnt - v0); end
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = valid_cnt;
        for (int i = 0; i < 3; i++) send_make(PS2_ARROW_RIGHT, 1'b0);
        @(negedge clk);
        n_cmp++; if (valid_cnt - v0 !== 3) begin n_err++; $display("FAIL typematic: got %0d pulses, required 3", valid_cnt - v0); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] c;
            logic       x;
            c = 8'($urandom_range(1, 8'h7F));
            x = 1'($urandom_range(0, 1));
            send_make(c, x);
            @(negedge clk);
            n_cmp++; if ({extended, key_code} !== {x, c}) begin n_err++; $display("FAIL random_make: got %b/%h, required %b/%h", extended, key_code, x, c); end
            if (i == 3) begin
                send_break(c, x);
                @(negedge clk);
                n_cmp++; if (key_code !== 8'h00) begin n_err++; $display("FAIL random_release: got %h, required 00", key_code); end
            end
        end
    endtask

    task automatic test_reset_mid;
        int v0;
        int e0;
        send_make(PS2_ARROW_LEFT, 1'b1);
        send_frame(PS2_BRK, 1'b0, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        v0 = valid_cnt;
        e0 = err_cnt;
        reset = 1'b0;
        wait_clks(3);
        @(negedge clk);
        n_cmp++; if ({extended, key_code} !== 9'h000) begin n_err++; $display("FAIL midreset_outputs: got %b/%h, required 0/00", extended, key_code); end
        reset = 1'b1;
        wait_clks(TMO + 50);
        n_cmp++; if (valid_cnt - v0 + err_cnt - e0 !== 0) begin n_err++; $display("FAIL midreset_pulses: got %0d, required 0", valid_cnt - v0 + err_cnt - e0); end
        // Break and extended flags were dropped, so this is a fresh plain make.
        send_make(PS2_ARROW_LEFT, 1'b0);
        @(negedge clk);
        n_cmp++; if ({extended, key_code} !== 9'h06B) begin n_err++; $display("FAIL midreset_make: got %b/%h, required 0/6b", extended, key_code); end
    endtask

    initial begin
        test_reset();
        test_make();
        test_extended();
        test_last_wins();
        test_parity();
        test_bad_stop();
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        wait_clks(10);
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expected keys never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the PS/2 keyboard serial stream, deserialises 11-bit device-to-host frames and decodes scan-code set 2 make/break sequences, including E0 extended prefixes. Presents a level `key_code` that holds the make code of the currently pressed key and is 0 when no key is held. Sits directly upstream of the maze movement stage, which compares `key_code[6:0]` against the arrow codes 0x6B, 0x74, 0x75 and 0x72.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronised samples of `ps2_clk` required before the filtered clock changes (range 2–255).
- `TIMEOUT_CYCLES`, default 50_000: idle `clk` cycles between PS/2 falling edges that abort a partial frame (1 ms at 50 MHz).
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock line, asynchronous.
- `ps2_data`  in  1  raw PS/2 data line, asynchronous.
- `key_code`  out  8  make code of the held key, without the E0 prefix; 0x00 when no key is held.
- `extended`  out  1  1 if the held key was E0-prefixed.
- `key_valid`  out  1  one-cycle pulse on every accepted make code, including typematic repeats.
- `frame_err`  out  1  one-cycle pulse on a discarded frame (bad stop bit, parity failure, or timeout).

## Operation
- `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser. `ps2_clk` is then glitch-filtered (`FILTER_LEN`). A falling edge of the filtered clock is the only sample strobe.
- Frame FSM, advancing on each strobe:
  - IDLE: if data=0 (start bit), go to DATA with bit count 0. If data=1, ignore the edge and stay in IDLE.
  - DATA: shift in 8 bits, LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: if data=1 and parity is acceptable, the byte is accepted. Otherwise pulse `frame_err`. Return to IDLE in either case.
- Timeout: in any state other than IDLE, a cycle counter resets on each strobe. When it reaches `TIMEOUT_CYCLES`, go to IDLE, discard the partial byte and pulse `frame_err`.
- Handling of accepted bytes:
  - 0xE0: set `ext_pend`.
  - 0xF0: set `brk_pend`.
  - Any other byte with `brk_pend`=1: if the byte equals `key_code` and `ext_pend` equals `extended`, clear `key_code` and `extended` to 0. Otherwise the outputs are unchanged, because a different key was released. Clear both pending flags.
  - Any other byte with `brk_pend`=0 (make): `key_code` takes the byte, `extended` takes `ext_pend`, pulse `key_valid`, and clear both pending flags.
- A new make while another key is held replaces it; last pressed wins.
- Reset mid-frame drops all state. No output pulses are generated from a partial frame.

## Timing
- Reset values: `key_code`=0x00, `extended`=0, `key_valid`=0, `frame_err`=0. FSM in IDLE, pending flags clear, counters 0.
- Strobe latency: 2 sync cycles + `FILTER_LEN` cycles + 1 edge-detect cycle after the raw `ps2_clk` falls.
- Byte latency: `key_code`, `extended` and the `key_valid`/`frame_err` pulses are registered on the cycle after the stop-bit strobe.
- The timeout `frame_err` pulse appears on the cycle after the counter reaches `TIMEOUT_CYCLES`.
- `key_valid` and `frame_err` are never asserted in the same cycle.

## Configuration
- `PS2_PARITY_CHECK_EN`
  - Defined: parity must be odd over the 8 data bits plus the parity bit. A mismatch discards the byte and pulses `frame_err`.
  - Undefined: the parity bit is captured and ignored, and `frame_err` is raised only for a bad stop bit or a timeout.

## Structure
- Package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - Arrow constants 8'h6B, 8'h74, 8'h75 and 8'h72, shared with the movement stage.
- Sub-module `ps2_line_filter`: synchroniser, `FILTER_LEN` glitch filter and falling-edge strobe for `ps2_clk`. `ps2_data` uses only the synchroniser.

## Test plan
- Frame 0x1C with odd parity and stop=1 → `key_valid` pulses once, `key_code`=0x1C, `extended`=0.
- Sequence E0 6B, then E0 F0 6B → `key_code`=0x6B with `extended`=1, then 0x00 with `extended`=0.
- Make 0x75, make 0x72, break 0x75 → `key_code` stays 0x72. A following break 0x72 → `key_code`=0x00.
- Frame 0x1C with even parity → with `PS2_PARITY_CHECK_EN` defined: `frame_err` pulses and `key_code` is unchanged. Undefined: `key_code`=0x1C.
- Stop the stream after 4 data bits and wait `TIMEOUT_CYCLES` → `frame_err` pulses once. A following full frame 0x74 decodes correctly.
- A 3-cycle low glitch on `ps2_clk` with `FILTER_LEN`=8 → no strobe and no state change. Assert `reset` mid-frame → all outputs return to reset values.
